// File: rtl/io_ready_pkg.sv
// io_ready_gen shared constants: instruction field layout, port index width
// and the decoder result bundle.
package io_ready_pkg;

    localparam int OPCODE_W = 4;
    localparam int D_W = 12;
    localparam int A_W = 10;
    localparam int B_W = 10;

    localparam int B_LSB = 0;
    localparam int A_LSB = B_LSB + B_W;
    localparam int D_LSB = A_LSB + A_W;
    localparam int OPCODE_LSB = D_LSB + D_W;

    localparam int PORTS = 8;
    localparam int PORT_IDX_W = $clog2(PORTS);

    typedef struct packed {
        logic                  hit;
        logic [PORT_IDX_W-1:0] index;
    } hit_t;

    function automatic logic [PORTS-1:0] strobe(input hit_t h, input logic en);
        strobe = '0;
        if (en && h.hit) strobe[h.index] = 1'b1;
    endfunction

endpackage

// File: rtl/delay_line.sv
// Fixed-depth register chain with synchronous clear; depth 0 is a wire.
module delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign q = d;
        end else begin : g_chain
            logic [WIDTH-1:0] stage [DEPTH];

            always_ff @(posedge clock) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
                end else begin
                    stage[0] <= d;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/io_port_decoder.sv
// Matches one operand address against a PORT-aligned I/O window and returns
// the hit flag plus the port index taken from the low address bits.
module io_port_decoder
    import io_ready_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int BASE       = 1016,
    parameter int COUNT      = PORTS
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output hit_t                  result
);

    localparam logic [31:0] LO = 32'(BASE);
    localparam logic [31:0] HI = 32'(BASE + COUNT);

    logic [31:0] wide;

    assign wide = 32'(addr);
    assign result.hit = (wide >= LO) && (wide < HI);
    assign result.index = addr[PORT_IDX_W-1:0];

endmodule

// File: rtl/io_ready_gen.sv
// Per-instruction I/O predicate and all-or-nothing port strobes.
// Optional IO_STALL_COUNT_EN adds per-thread stall counters and stall_count.
module io_ready_gen
    import io_ready_pkg::*;
#(
    parameter int INSTR_WIDTH       = 36,
    parameter int OPCODE_WIDTH      = OPCODE_W,
    parameter int D_OPERAND_WIDTH   = D_W,
    parameter int A_OPERAND_WIDTH   = A_W,
    parameter int B_OPERAND_WIDTH   = B_W,
    parameter int PORT_COUNT        = PORTS,
    parameter int A_READ_BASE       = 1016,
    parameter int B_READ_BASE       = 1016,
    parameter int A_WRITE_BASE      = 1016,
    parameter int B_WRITE_BASE      = 2040,
    parameter int WRITE_DELAY       = 6,
    parameter int THREAD_COUNT      = 8,
    parameter int THREAD_ADDR_WIDTH = 3,
    parameter int STALL_COUNT_WIDTH = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [INSTR_WIDTH-1:0]       I_read_data,
    input  logic [PORT_COUNT-1:0]        A_in_ready,
    input  logic [PORT_COUNT-1:0]        B_in_ready,
    input  logic [PORT_COUNT-1:0]        A_out_ready,
    input  logic [PORT_COUNT-1:0]        B_out_ready,
    output logic                         IO_ready,
    output logic [PORT_COUNT-1:0]        A_rden,
    output logic [PORT_COUNT-1:0]        B_rden,
    output logic [PORT_COUNT-1:0]        A_wren,
    output logic [PORT_COUNT-1:0]        B_wren,
`ifdef IO_STALL_COUNT_EN
    output logic [STALL_COUNT_WIDTH-1:0] stall_count,
`endif
    output logic                         wren_other
);

    localparam int B_OFS = 0;
    localparam int A_OFS = B_OFS + B_OPERAND_WIDTH;
    localparam int D_OFS = A_OFS + A_OPERAND_WIDTH;

    hit_t a_hit, b_hit, da_hit, db_hit;
    hit_t s1_a, s1_b, s1_da, s1_db;
    logic s1_valid;
    logic [PORT_COUNT-1:0] s1_ain, s1_bin, s1_aout, s1_bout;
    logic ok;
    logic [PORT_COUNT-1:0] a_wr, b_wr;
    logic [THREAD_ADDR_WIDTH-1:0] thread;
    logic unused_opcode;

    assign unused_opcode = ^I_read_data[INSTR_WIDTH-1 -: OPCODE_WIDTH];

    io_port_decoder #(
        .ADDR_WIDTH(A_OPERAND_WIDTH), .BASE(A_READ_BASE), .COUNT(PORT_COUNT)
    ) u_dec_a (
        .addr(I_read_data[A_OFS +: A_OPERAND_WIDTH]), .result(a_hit)
    );

    io_port_decoder #(
        .ADDR_WIDTH(B_OPERAND_WIDTH), .BASE(B_READ_BASE), .COUNT(PORT_COUNT)
    ) u_dec_b (
        .addr(I_read_data[B_OFS +: B_OPERAND_WIDTH]), .result(b_hit)
    );

    io_port_decoder #(
        .ADDR_WIDTH(D_OPERAND_WIDTH), .BASE(A_WRITE_BASE), .COUNT(PORT_COUNT)
    ) u_dec_da (
        .addr(I_read_data[D_OFS +: D_OPERAND_WIDTH]), .result(da_hit)
    );

    io_port_decoder #(
        .ADDR_WIDTH(D_OPERAND_WIDTH), .BASE(B_WRITE_BASE), .COUNT(PORT_COUNT)
    ) u_dec_db (
        .addr(I_read_data[D_OFS +: D_OPERAND_WIDTH]), .result(db_hit)
    );

    // s1_valid keeps the reset-cleared slot from looking like a no-hit pass.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_da    <= '0;
            s1_db    <= '0;
            s1_ain   <= '0;
            s1_bin   <= '0;
            s1_aout  <= '0;
            s1_bout  <= '0;
        end else begin
            s1_valid <= 1'b1;
            s1_a     <= a_hit;
            s1_b     <= b_hit;
            s1_da    <= da_hit;
            s1_db    <= db_hit;
            s1_ain   <= A_in_ready;
            s1_bin   <= B_in_ready;
            s1_aout  <= A_out_ready;
            s1_bout  <= B_out_ready;
        end
    end

    always_comb begin
        ok = s1_valid;
        if (s1_a.hit && !s1_ain[s1_a.index]) ok = 1'b0;
        if (s1_b.hit && !s1_bin[s1_b.index]) ok = 1'b0;
        if (s1_da.hit && !s1_aout[s1_da.index]) ok = 1'b0;
        if (s1_db.hit && !s1_bout[s1_db.index]) ok = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            IO_ready <= 1'b0;
            A_rden   <= '0;
            B_rden   <= '0;
            a_wr     <= '0;
            b_wr     <= '0;
        end else begin
            IO_ready <= ok;
            A_rden   <= strobe(s1_a, ok);
            B_rden   <= strobe(s1_b, ok);
            a_wr     <= strobe(s1_da, ok);
            b_wr     <= strobe(s1_db, ok);
        end
    end

    delay_line #(
        .WIDTH(2 * PORT_COUNT + 1), .DEPTH(WRITE_DELAY)
    ) u_wr_delay (
        .clock(clock),
        .reset(reset),
        .d({a_wr, b_wr, IO_ready}),
        .q({A_wren, B_wren, wren_other})
    );

    // Counter value names the thread whose instruction sits in stage 2.
    always_ff @(posedge clock) begin
        if (reset) begin
            thread <= '0;
        end else if (thread == THREAD_ADDR_WIDTH'(THREAD_COUNT - 1)) begin
            thread <= '0;
        end else begin
            thread <= thread + 1'b1;
        end
    end

`ifdef IO_STALL_COUNT_EN
    logic [STALL_COUNT_WIDTH-1:0] counts [THREAD_COUNT];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < THREAD_COUNT; i++) counts[i] <= '0;
            stall_count <= '0;
        end else begin
            stall_count <= counts[thread];
            if (s1_valid && !ok && counts[thread] != '1) begin
                counts[thread] <= counts[thread] + 1'b1;
            end
        end
    end
`else
    logic unused_thread;
    assign unused_thread = ^thread;
`endif

endmodule

// File: tb/tb_io_ready_gen.sv
// Table-driven scoreboard bench for io_ready_gen; the stall-counter
// phase is built only with IO_STALL_COUNT_EN.
module tb_io_ready_gen;

`ifdef IO_STALL_COUNT_EN
    localparam int SCW = 4;
`else
    localparam int SCW = 16;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [35:0] I_read_data = '0;
    logic [7:0]  A_in_ready = '0, B_in_ready = '0;
    logic [7:0]  A_out_ready = '0, B_out_ready = '0;
    logic        IO_ready, wren_other;
    logic [7:0]  A_rden, B_rden, A_wren, B_wren;
`ifdef IO_STALL_COUNT_EN
    logic [SCW-1:0] stall_count;
`endif

    io_ready_gen #(.STALL_COUNT_WIDTH(SCW)) dut (
        .clock(clock),
        .reset(reset),
        .I_read_data(I_read_data),
        .A_in_ready(A_in_ready),
        .B_in_ready(B_in_ready),
        .A_out_ready(A_out_ready),
        .B_out_ready(B_out_ready),
        .IO_ready(IO_ready),
        .A_rden(A_rden),
        .B_rden(B_rden),
        .A_wren(A_wren),
        .B_wren(B_wren),
`ifdef IO_STALL_COUNT_EN
        .stall_count(stall_count),
`endif
        .wren_other(wren_other)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [9:0]  a;
        logic [9:0]  b;
        logic [11:0] d;
        logic [7:0]  ain, bin, aout, bout;
        logic        io;
        logic [7:0]  ar, br, aw, bw;
    } vec_t;

    typedef struct {
        int             due;
        logic           io;
        logic [7:0]     ar, br;
        logic           chk_sc;
        logic [SCW-1:0] sc;
    } rd_t;

    typedef struct {
        int         due;
        logic [7:0] aw, bw;
        logic       wo;
    } wr_t;

    vec_t vecs [15];
    vec_t idle, blocked;
    rd_t  rq [$];
    wr_t  wq [$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic           exp_sc_en = 1'b0;
    logic [SCW-1:0] exp_sc = '0;

    function automatic vec_t mk(
        input logic [9:0] a, input logic [9:0] b, input logic [11:0] d,
        input logic [7:0] ain, input logic [7:0] bin,
        input logic [7:0] aout, input logic [7:0] bout,
        input logic io, input logic [7:0] ar, input logic [7:0] br,
        input logic [7:0] aw, input logic [7:0] bw);
        vec_t v;
        v.a = a; v.b = b; v.d = d;
        v.ain = ain; v.bin = bin; v.aout = aout; v.bout = bout;
        v.io = io; v.ar = ar; v.br = br; v.aw = aw; v.bw = bw;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d actual=%h required=%h",
                     name, cyc, act, exp);
        end
    endtask

    task automatic compare_due();
        rd_t r;
        wr_t w;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            r = rq.pop_front();
            check("io_ready", 32'(IO_ready), 32'(r.io));
            check("a_rden", 32'(A_rden), 32'(r.ar));
            check("b_rden", 32'(B_rden), 32'(r.br));
`ifdef IO_STALL_COUNT_EN
            if (r.chk_sc) check("stall_count", 32'(stall_count), 32'(r.sc));
`endif
        end
        if (wq.size() > 0 && wq[0].due == cyc) begin
            w = wq.pop_front();
            check("a_wren", 32'(A_wren), 32'(w.aw));
            check("b_wren", 32'(B_wren), 32'(w.bw));
            check("wren_other", 32'(wren_other), 32'(w.wo));
        end
    endtask

    task automatic tick(input vec_t v, input logic rst);
        rd_t r;
        wr_t w;
        @(negedge clock);
        cyc++;
        compare_due();
        I_read_data = {4'($urandom), v.d, v.a, v.b};
        A_in_ready = v.ain;
        B_in_ready = v.bin;
        A_out_ready = v.aout;
        B_out_ready = v.bout;
        reset = rst;
        if (rst) begin
            // everything still in flight is discarded by the reset edge
            for (int i = 0; i < rq.size(); i++) begin
                r = rq[i];
                r.io = 1'b0; r.ar = '0; r.br = '0; r.sc = '0;
                rq[i] = r;
            end
            for (int i = 0; i < wq.size(); i++) begin
                w = wq[i];
                w.aw = '0; w.bw = '0; w.wo = 1'b0;
                wq[i] = w;
            end
        end
        r.due = cyc + 2;
        r.io = rst ? 1'b0 : v.io;
        r.ar = rst ? 8'h00 : v.ar;
        r.br = rst ? 8'h00 : v.br;
        r.chk_sc = exp_sc_en;
        r.sc = exp_sc;
        rq.push_back(r);
        w.due = cyc + 8;
        w.aw = rst ? 8'h00 : v.aw;
        w.bw = rst ? 8'h00 : v.bw;
        w.wo = rst ? 1'b0 : v.io;
        wq.push_back(w);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (rq.size() > 0 || wq.size() > 0); i++) begin
            @(negedge clock);
            cyc++;
            compare_due();
        end
        check("queue_empty", 32'(rq.size() + wq.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=running required=done", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        idle    = mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0, 0);
        blocked = mk(1017, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0);
        vecs[0]  = mk(1017, 0, 0, 8'h02, 8'h00, 8'h00, 8'h00,
                      1, 8'h02, 8'h00, 8'h00, 8'h00);
        vecs[1]  = blocked;
        vecs[2]  = mk(1016, 0, 2043, 8'h01, 8'h00, 8'hFF, 8'h00,
                      0, 8'h00, 8'h00, 8'h00, 8'h00);
        vecs[3]  = mk(1019, 1020, 1023, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                      1, 8'h08, 8'h10, 8'h80, 8'h00);
        vecs[4]  = idle;
        vecs[5]  = mk(0, 0, 2047, 8'h00, 8'h00, 8'h00, 8'h80,
                      1, 8'h00, 8'h00, 8'h00, 8'h80);
        vecs[6]  = mk(0, 1023, 0, 8'h00, 8'h7F, 8'h00, 8'h00,
                      0, 8'h00, 8'h00, 8'h00, 8'h00);
        vecs[7]  = mk(0, 1015, 0, 8'h00, 8'h00, 8'h00, 8'h00,
                      1, 8'h00, 8'h00, 8'h00, 8'h00);
        vecs[8]  = mk(1023, 1016, 2040, 8'h80, 8'h01, 8'h00, 8'h01,
                      1, 8'h80, 8'h01, 8'h00, 8'h01);
        vecs[9]  = mk(0, 0, 1016, 8'h00, 8'h00, 8'hFE, 8'h00,
                      0, 8'h00, 8'h00, 8'h00, 8'h00);
        vecs[10] = mk(1000, 0, 2039, 8'h00, 8'h00, 8'h00, 8'h00,
                      1, 8'h00, 8'h00, 8'h00, 8'h00);
        vecs[11] = mk(1020, 0, 4095, 8'h10, 8'h00, 8'h00, 8'h00,
                      1, 8'h10, 8'h00, 8'h00, 8'h00);
        vecs[12] = mk(0, 0, 1024, 8'h00, 8'h00, 8'h00, 8'h00,
                      1, 8'h00, 8'h00, 8'h00, 8'h00);
        vecs[13] = mk(1018, 1017, 1021, 8'h04, 8'h02, 8'h20, 8'h00,
                      1, 8'h04, 8'h02, 8'h20, 8'h00);
        vecs[14] = mk(1018, 1017, 1021, 8'h04, 8'h02, 8'hDF, 8'hFF,
                      0, 8'h00, 8'h00, 8'h00, 8'h00);

        for (int i = 0; i < 3; i++) tick(idle, 1'b1);
        for (int i = 0; i < 15; i++) tick(vecs[i], 1'b0);

        // write strobe in the delay chain when reset hits
        tick(vecs[3], 1'b0);
        tick(idle, 1'b0);
        tick(idle, 1'b0);
        tick(idle, 1'b1);
        tick(idle, 1'b1);
        for (int i = 0; i < 4; i++) tick(idle, 1'b0);
        tick(vecs[8], 1'b0);
        drain();

`ifdef IO_STALL_COUNT_EN
        // fetch k after release runs in stage 2 as thread (k+1) mod 8
        tick(idle, 1'b1);
        tick(idle, 1'b1);
        for (int k = 0; k < 48; k++) begin
            if (k >= 40) begin
                exp_sc_en = 1'b1;
                exp_sc = (((k + 1) % 8) == 3) ? SCW'(5) : '0;
            end
            if (k < 40 && ((k + 1) % 8) == 3) tick(blocked, 1'b0);
            else tick(idle, 1'b0);
        end
        exp_sc_en = 1'b0;
        for (int k = 48; k < 48 + 8 * 17; k++) tick(blocked, 1'b0);
        exp_sc_en = 1'b1;
        exp_sc = '1;
        for (int k = 0; k < 16; k++) tick(blocked, 1'b0);
        exp_sc_en = 1'b0;
        drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
